// File: rtl/axi_resp_router.sv
// Purpose : steer one downstream response stream (R or B beats) back to requestors in arbiter grant order.
// Latency : routing is combinational; a recorded grant becomes routable the cycle after it is pushed.
// Backpr. : grant_ready_o drops at DEPTH outstanding; in_ready_o follows the selected requestor's ready, and is low when empty.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   grant_valid_i/sel_i   completed arbiter grant and the winning requestor index
//   grant_ready_o         order FIFO has room for another grant
//   in_valid/ready/last/data   single response stream from downstream
//   out_valid_o[NUM_REQ]  one-hot valid toward the requestor at the FIFO head
//   out_ready_i[NUM_REQ]  per-requestor ready; only the head's bit is used
//   out_last_o/out_data_o broadcast copies of in_last_i/in_data_i
//   outstanding_o         number of grants still awaiting their last beat
//   bad_sel_o             head entry names a requestor that does not exist
module axi_resp_router #(
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    localparam int SEL_W     = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  grant_valid_i,
    input  logic [SEL_W-1:0]      grant_sel_i,
    output logic                  grant_ready_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_last_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic [NUM_REQ-1:0]    out_valid_o,
    input  logic [NUM_REQ-1:0]    out_ready_i,
    output logic                  out_last_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  bad_sel_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SEL_W-1:0] sel_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [SEL_W-1:0] head;
    logic             empty;
    logic             head_bad;
    logic             push;
    logic             pop;

    // DEPTH need not be a power of two, so wrap by compare instead of masking.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty         = (count == '0);
    assign grant_ready_o = (count != CNT_W'(DEPTH));
    assign outstanding_o = count;
    assign head          = sel_mem[rd_ptr];

    // Only reachable when NUM_REQ is not a power of two; the extra bit keeps
    // the compare wide enough to hold NUM_REQ itself.
    assign head_bad  = !empty && ({1'b0, head} >= (SEL_W + 1)'(NUM_REQ));
    assign bad_sel_o = head_bad;

    assign out_data_o = in_data_i;
    assign out_last_o = in_last_i;

    always_comb begin
        out_valid_o = '0;
        if (in_valid_i && !empty && !head_bad) begin
            out_valid_o[head] = 1'b1;
        end
    end

    // A bad head has no requestor to wait on, so its beats are drained.
    always_comb begin
        in_ready_o = 1'b0;
        if (!empty) begin
            in_ready_o = head_bad ? 1'b1 : out_ready_i[head];
        end
    end

    assign push = grant_valid_i && grant_ready_o;
    assign pop  = in_valid_i && in_ready_o && in_last_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Full-and-pop cannot push (grant_ready_o is low), so a freed
            // slot is only offered from the following cycle.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: it is never read while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            sel_mem[wr_ptr] <= grant_sel_i;
        end
    end

endmodule
